ring_node_arbiter: RTL and testbench

Round-robin scheduler for a ring-network node. It accepts packets from the left neighbour, the right neighbour and the local host, then grants one packet per cycle. Each granted packet goes to one of two output registers, chosen by the packet's destination field: local delivery when the destination equals this node, otherwise the ring forwarding stage. It is the sequencing and arbitration stage that sits between the node's receive conditioners and its forwarding/ejection logic.

---
 rtl/ring_pkg.sv | 21 ++
 rtl/rr_pick3.sv | 32 +++
 rtl/ring_node_arbiter.sv | 133 +++++++++++++
 tb/tb_ring_node_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring node: source codes and the destination-field helper.
package ring_pkg;

    typedef enum logic [1:0] {
        SRC_LEFT  = 2'b00,
        SRC_SELF  = 2'b01,
        SRC_RIGHT = 2'b10,
        SRC_NONE  = 2'b11
    } src_e;

    localparam int PKT_MAX  = 128;
    localparam int DEST_MAX = 8;

    // Destination sits in the top addr_bits of the packet; callers zero-extend to PKT_MAX.
    function automatic logic [DEST_MAX-1:0] dest_field(input logic [PKT_MAX-1:0] data,
                                                       input int unsigned w,
                                                       input int unsigned ab);
        return DEST_MAX'(data >> (w - ab)) & DEST_MAX'((1 << ab) - 1);
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: first eligible source at or after the pointer wins.
module rr_pick3
    import ring_pkg::*;
(
    input  logic [2:0] elig_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] grantOh_o,
    output logic [1:0] winner_o
);

    src_e order0, order1, order2, winner;

    always_comb begin
        order0 = SRC_LEFT;
        order1 = SRC_SELF;
        order2 = SRC_RIGHT;
        case (ptr_i)
            2'd1: begin order0 = SRC_SELF;  order1 = SRC_RIGHT; order2 = SRC_LEFT; end
            2'd2: begin order0 = SRC_RIGHT; order1 = SRC_LEFT;  order2 = SRC_SELF; end
            default: ;
        endcase

        winner = SRC_NONE;
        if (elig_i[order0])      winner = order0;
        else if (elig_i[order1]) winner = order1;
        else if (elig_i[order2]) winner = order2;

        grantOh_o = (winner == SRC_NONE) ? 3'b000 : (3'b001 << winner);
        winner_o  = winner;
    end

endmodule

// File: rtl/ring_node_arbiter.sv
// Ring node scheduler: three capture slots arbitrated round-robin into ring and local output registers.
module ring_node_arbiter
    import ring_pkg::*;
#(
    parameter int width     = 32,
    parameter int addr_bits = 2,
    parameter int node_id   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] left_data,
    input  logic             left_valid,
    output logic             left_ready,
    input  logic [width-1:0] self_data,
    input  logic             self_valid,
    output logic             self_ready,
    input  logic [width-1:0] right_data,
    input  logic             right_valid,
    output logic             right_ready,
    output logic [width-1:0] ring_data,
    output logic             ring_valid,
    input  logic             ring_ready,
    output logic [width-1:0] local_data,
    output logic             local_valid,
    input  logic             local_ready,
    output logic [1:0]       grant,
    output logic             busy
);

    logic [2:0]       slotValid_q, slotValid_d;
    logic [width-1:0] slotData_q [3];
    logic [width-1:0] inData [3];
    logic [2:0]       inValid;

    logic             ringValid_q, ringValid_d, localValid_q, localValid_d;
    logic [width-1:0] ringData_q, localData_q;
    src_e             ptr_q, ptr_d, grant_q, grant_d;

    logic [2:0]       toLocal, elig, pickOh;
    logic [1:0]       pickWin;
    logic             ringAvail, localAvail, anyGrant, winLocal, ringLoad, localLoad;
    logic [width-1:0] winData;

    assign inValid   = {right_valid, self_valid, left_valid};
    assign inData[0] = left_data;
    assign inData[1] = self_data;
    assign inData[2] = right_data;

    // An output can take a packet if it is empty or draining at this edge.
    assign ringAvail  = ~ringValid_q | ring_ready;
    assign localAvail = ~localValid_q | local_ready;

    always_comb begin
        toLocal = '0;
        elig    = '0;
        for (int i = 0; i < 3; i++) begin
            toLocal[i] = (dest_field(PKT_MAX'(slotData_q[i]), width, addr_bits) == DEST_MAX'(node_id));
            elig[i]    = slotValid_q[i] & (toLocal[i] ? localAvail : ringAvail);
        end
    end

    rr_pick3 u_pick (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
        .grantOh_o (pickOh),
        .winner_o  (pickWin)
    );

    always_comb begin
        winData  = slotData_q[0];
        winLocal = toLocal[0];
        case (pickWin)
            SRC_SELF:  begin winData = slotData_q[1]; winLocal = toLocal[1]; end
            SRC_RIGHT: begin winData = slotData_q[2]; winLocal = toLocal[2]; end
            default: ;
        endcase

        anyGrant  = |pickOh;
        ringLoad  = anyGrant & ~winLocal;
        localLoad = anyGrant & winLocal;

        // A granted slot was full, so it cannot also capture at the same edge.
        slotValid_d  = (slotValid_q & ~pickOh) | (inValid & ~slotValid_q);
        ringValid_d  = ringLoad | (ringValid_q & ~ring_ready);
        localValid_d = localLoad | (localValid_q & ~local_ready);

        ptr_d   = ptr_q;
        grant_d = SRC_NONE;
        if (anyGrant) begin
            grant_d = src_e'(pickWin);
            case (pickWin)
                SRC_LEFT: ptr_d = SRC_SELF;
                SRC_SELF: ptr_d = SRC_RIGHT;
                default:  ptr_d = SRC_LEFT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slotValid_q  <= '0;
            for (int i = 0; i < 3; i++) slotData_q[i] <= '0;
            ringValid_q  <= 1'b0;
            localValid_q <= 1'b0;
            ringData_q   <= '0;
            localData_q  <= '0;
            ptr_q        <= SRC_LEFT;
            grant_q      <= SRC_NONE;
        end else begin
            slotValid_q  <= slotValid_d;
            for (int i = 0; i < 3; i++) begin
                if (inValid[i] & ~slotValid_q[i]) slotData_q[i] <= inData[i];
            end
            ringValid_q  <= ringValid_d;
            localValid_q <= localValid_d;
            if (ringLoad)  ringData_q  <= winData;
            if (localLoad) localData_q <= winData;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
        end
    end

    assign left_ready  = ~slotValid_q[0];
    assign self_ready  = ~slotValid_q[1];
    assign right_ready = ~slotValid_q[2];
    assign ring_data   = ringData_q;
    assign ring_valid  = ringValid_q;
    assign local_data  = localData_q;
    assign local_valid = localValid_q;
    assign grant       = grant_q;
    assign busy        = |slotValid_q | ringValid_q | localValid_q;

endmodule

// File: tb/tb_ring_node_arbiter.sv
// Bench for ring_node_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_ring_node_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] left_data, self_data, right_data;
    logic        left_valid, self_valid, right_valid;
    logic        left_ready, self_ready, right_ready;
    logic [31:0] ring_data, local_data;
    logic        ring_valid, ring_ready, local_valid, local_ready;
    logic [1:0]  grant;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    bit          mV [3];
    logic [31:0] mD [3];
    bit          mRV, mLV;
    logic [31:0] mRD, mLD;
    int          mPtr;
    logic [1:0]  mGrant;

    always #5 clk = ~clk;

    ring_node_arbiter #(.width(32), .addr_bits(2), .node_id(1)) dut (
        .clk(clk), .reset(reset),
        .left_data(left_data), .left_valid(left_valid), .left_ready(left_ready),
        .self_data(self_data), .self_valid(self_valid), .self_ready(self_ready),
        .right_data(right_data), .right_valid(right_valid), .right_ready(right_ready),
        .ring_data(ring_data), .ring_valid(ring_valid), .ring_ready(ring_ready),
        .local_data(local_data), .local_valid(local_valid), .local_ready(local_ready),
        .grant(grant), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        {left_valid, self_valid, right_valid} = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        {left_valid, self_valid, right_valid} = 3'b111;
        left_data = 32'hFFFF_FFFF; self_data = 32'hFFFF_FFFF; right_data = 32'hFFFF_FFFF;
        ring_ready = 1'b1; local_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({ring_valid, local_valid, busy, grant} !== 5'b00011) begin
                miscompares++;
                $display("[TB] FAIL reset_ctrl got=%b want=00011", {ring_valid, local_valid, busy, grant});
            end
            vectors++;
            if ({ring_data, local_data} !== 64'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_data got=%h want=0", {ring_data, local_data});
            end
        end
        {left_valid, self_valid, right_valid} = 3'b000;
        reset = 1'b0;
        vectors++;
        if ({left_ready, self_ready, right_ready} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL reset_ready got=%b want=111", {left_ready, self_ready, right_ready});
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_nocapture busy got=%b want=0", busy);
        end
    endtask

    task automatic test_single_local;
        left_data = 32'h4000_00AA; left_valid = 1'b1;
        tick();
        left_valid = 1'b0;
        vectors++;
        if ({left_ready, local_valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_capture got=%b want=00", {left_ready, local_valid});
        end
        tick();
        vectors++;
        if ({local_valid, ring_valid, grant} !== 4'b1000 || local_data !== 32'h4000_00AA) begin
            miscompares++;
            $display("[TB] FAIL single_out got=%b/%h want=1000/400000aa", {local_valid, ring_valid, grant}, local_data);
        end
        tick();
        vectors++;
        if ({local_valid, grant} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL single_drain got=%b want=011", {local_valid, grant});
        end
    endtask

    task automatic test_contention;
        logic [31:0] expD [3];
        expD = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003};
        do_reset();
        ring_ready = 1'b1;
        left_data = expD[0]; self_data = expD[1]; right_data = expD[2];
        {left_valid, self_valid, right_valid} = 3'b111;
        tick();
        {left_valid, self_valid, right_valid} = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (ring_valid !== 1'b1 || ring_data !== expD[i] || grant !== 2'(i)) begin
                miscompares++;
                $display("[TB] FAIL contention_%0d got=%b/%h/%0d want=1/%h/%0d", i, ring_valid, ring_data, grant, expD[i], i);
            end
        end
        tick();
        vectors++;
        if ({ring_valid, grant, busy} !== 4'b0110) begin
            miscompares++;
            $display("[TB] FAIL contention_end got=%b want=0110", {ring_valid, grant, busy});
        end
    endtask

    task automatic test_bypass;
        ring_ready = 1'b0; local_ready = 1'b1;
        right_data = 32'h8000_0099; right_valid = 1'b1;
        tick();
        right_valid = 1'b0;
        tick();
        left_data = 32'h0000_0011; self_data = 32'h4000_0022;
        left_valid = 1'b1; self_valid = 1'b1;
        tick();
        left_valid = 1'b0; self_valid = 1'b0;
        tick();
        vectors++;
        if (grant !== 2'b01 || local_valid !== 1'b1 || local_data !== 32'h4000_0022) begin
            miscompares++;
            $display("[TB] FAIL bypass_self got=%0d/%b/%h want=1/1/40000022", grant, local_valid, local_data);
        end
        vectors++;
        if (left_ready !== 1'b0 || ring_data !== 32'h8000_0099 || ring_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bypass_hold got=%b/%h/%b want=0/80000099/1", left_ready, ring_data, ring_valid);
        end
        tick();
        ring_ready = 1'b1;
        vectors++;
        if (grant !== 2'b11 || left_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bypass_wait got=%0d/%b want=3/0", grant, left_ready);
        end
        tick();
        vectors++;
        if (grant !== 2'b00 || ring_valid !== 1'b1 || ring_data !== 32'h0000_0011 || left_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bypass_left got=%0d/%b/%h/%b want=0/1/00000011/1", grant, ring_valid, ring_data, left_ready);
        end
        tick();
        vectors++;
        if ({ring_valid, local_valid, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL bypass_end got=%b want=000", {ring_valid, local_valid, busy});
        end
    endtask

    task automatic test_fairness;
        int cntL, cntR;
        logic [1:0] prevG;
        cntL = 0; cntR = 0; prevG = 2'b11;
        ring_ready = 1'b1; local_ready = 1'b1;
        left_data = 32'h8000_00A1; right_data = 32'h8000_00A3;
        left_valid = 1'b1; right_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (grant == 2'b00) cntL++;
            if (grant == 2'b10) cntR++;
            vectors++;
            if (grant == 2'b01 || (grant != 2'b11 && grant == prevG)) begin
                miscompares++;
                $display("[TB] FAIL fair_seq cycle %0d got=%0d prev=%0d want alternating 0/2", c, grant, prevG);
            end
            if (grant != 2'b11) begin
                vectors++;
                if (ring_data !== ((grant == 2'b00) ? 32'h8000_00A1 : 32'h8000_00A3)) begin
                    miscompares++;
                    $display("[TB] FAIL fair_data cycle %0d grant=%0d got=%h", c, grant, ring_data);
                end
            end
            prevG = grant;
        end
        vectors++;
        if (cntL + cntR < 18 || cntL - cntR > 1 || cntR - cntL > 1) begin
            miscompares++;
            $display("[TB] FAIL fair_count got left=%0d right=%0d want >=18 total, diff<=1", cntL, cntR);
        end
        left_valid = 1'b0; right_valid = 1'b0;
        repeat (4) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fair_drain busy got=%b want=0", busy);
        end
    endtask

    task automatic test_reset_mid;
        ring_ready = 1'b0;
        right_data = 32'h8000_00D3; right_valid = 1'b1;
        tick();
        right_valid = 1'b0;
        tick();
        left_data = 32'h8000_00D1; self_data = 32'h8000_00D2;
        left_valid = 1'b1; self_valid = 1'b1;
        tick();
        left_valid = 1'b0; self_valid = 1'b0;
        vectors++;
        if ({ring_valid, left_ready, self_ready} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL midreset_setup got=%b want=100", {ring_valid, left_ready, self_ready});
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({ring_valid, local_valid, busy, grant, left_ready, self_ready, right_ready} !== 8'b00011111 || ring_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_state got=%b/%h want=00011111/0",
                     {ring_valid, local_valid, busy, grant, left_ready, self_ready, right_ready}, ring_data);
        end
        reset = 1'b0;
        ring_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if ({ring_valid, local_valid, grant} !== 4'b0011) begin
                miscompares++;
                $display("[TB] FAIL midreset_ghost cycle %0d got=%b want=0011", c, {ring_valid, local_valid, grant});
            end
        end
        left_data = 32'h8000_00E1; self_data = 32'h8000_00E2; right_data = 32'h8000_00E3;
        {left_valid, self_valid, right_valid} = 3'b111;
        tick();
        {left_valid, self_valid, right_valid} = 3'b000;
        tick();
        vectors++;
        if (grant !== 2'b00 || ring_data !== 32'h8000_00E1) begin
            miscompares++;
            $display("[TB] FAIL midreset_ptr got=%0d/%h want=0/800000e1", grant, ring_data);
        end
        repeat (3) tick();
    endtask

    task automatic model_reset;
        for (int s = 0; s < 3; s++) begin mV[s] = 1'b0; mD[s] = '0; end
        mRV = 1'b0; mLV = 1'b0; mRD = '0; mLD = '0; mPtr = 0; mGrant = 2'b11;
    endtask

    task automatic model_step;
        bit          cap [3];
        bit          inV [3];
        logic [31:0] inD [3];
        bit          ringFree, localFree, lcl;
        int          win;
        if (reset) begin
            model_reset();
            return;
        end
        inV = '{left_valid, self_valid, right_valid};
        inD = '{left_data, self_data, right_data};
        ringFree  = !mRV || ring_ready;
        localFree = !mLV || local_ready;
        win = -1;
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (mPtr + k) % 3;
            if (win < 0 && mV[s]) begin
                lcl = (mD[s][31:30] == 2'd1);
                if (lcl ? localFree : ringFree) win = s;
            end
        end
        for (int s = 0; s < 3; s++) cap[s] = !mV[s] && inV[s];
        if (mRV && ring_ready) mRV = 1'b0;
        if (mLV && local_ready) mLV = 1'b0;
        if (win >= 0) begin
            mV[win] = 1'b0;
            if (mD[win][31:30] == 2'd1) begin mLV = 1'b1; mLD = mD[win]; end
            else begin mRV = 1'b1; mRD = mD[win]; end
            mPtr = (win + 1) % 3;
            mGrant = 2'(win);
        end else begin
            mGrant = 2'b11;
        end
        for (int s = 0; s < 3; s++) if (cap[s]) begin mV[s] = 1'b1; mD[s] = inD[s]; end
    endtask

    task automatic test_random;
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(0, 49) == 0);
            left_valid  = $urandom_range(0, 1) == 1;
            self_valid  = $urandom_range(0, 1) == 1;
            right_valid = $urandom_range(0, 1) == 1;
            left_data   = $urandom;
            self_data   = $urandom;
            right_data  = $urandom;
            ring_ready  = $urandom_range(0, 9) < 6;
            local_ready = $urandom_range(0, 9) < 6;
            model_step();
            tick();
            vectors++;
            if ({left_ready, self_ready, right_ready} !== {!mV[0], !mV[1], !mV[2]} || grant !== mGrant ||
                busy !== (mV[0] | mV[1] | mV[2] | mRV | mLV)) begin
                miscompares++;
                $display("[TB] FAIL rand_ctrl cycle %0d rdy=%b grant=%0d busy=%b want rdy=%b grant=%0d", c,
                         {left_ready, self_ready, right_ready}, grant, busy, {!mV[0], !mV[1], !mV[2]}, mGrant);
            end
            vectors++;
            if (ring_valid !== mRV || ring_data !== mRD || local_valid !== mLV || local_data !== mLD) begin
                miscompares++;
                $display("[TB] FAIL rand_out cycle %0d ring=%b/%h local=%b/%h want ring=%b/%h local=%b/%h", c,
                         ring_valid, ring_data, local_valid, local_data, mRV, mRD, mLV, mLD);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {left_valid, self_valid, right_valid} = 3'b000;
        left_data = '0; self_data = '0; right_data = '0;
        ring_ready = 1'b0; local_ready = 1'b0;
        test_reset();
        test_single_local();
        test_contention();
        test_bypass();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
